// File: rtl/input_conditioner.sv
// Two-channel button front end: 2-flop sync, counter debounce, rising-edge pulse.
// Channel 0 drives A/a_level, channel 1 drives B/b_level.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_a_raw,
    input  logic btn_b_raw,
    output logic A,
    output logic B,
    output logic a_level,
    output logic b_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       w_raw;
    logic [1:0]       w_diff;
    logic [1:0]       w_done;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_level;
    logic [1:0]       r_pulse;
    logic [CNT_W-1:0] r_cnt [2];

    assign w_raw = {btn_b_raw, btn_a_raw};

    // w_done marks the edge on which the level flips to sync2
    always_comb begin
        w_diff = '0;
        w_done = '0;
        for (int c = 0; c < 2; c++) begin
            w_diff[c] = r_sync2[c] ^ r_level[c];
            w_done[c] = w_diff[c] && (r_cnt[c] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_pulse <= '0;
            for (int c = 0; c < 2; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int c = 0; c < 2; c++) begin
                r_pulse[c] <= w_done[c] & r_sync2[c];
                if (w_done[c]) begin
                    r_level[c] <= r_sync2[c];
                end
                if (!w_diff[c] || w_done[c]) begin
                    r_cnt[c] <= '0;
                end else begin
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    end

    assign A       = r_pulse[0];
    assign B       = r_pulse[1];
    assign a_level = r_level[0];
    assign b_level = r_level[1];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: window-based reference model plus directed scenarios.
module tb_input_conditioner;

    localparam int D    = 4;
    localparam int MAXE = 8192;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_a_raw = 1'b0;
    logic btn_b_raw = 1'b0;
    logic A, B, a_level, b_level;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .reset(reset),
        .btn_a_raw(btn_a_raw),
        .btn_b_raw(btn_b_raw),
        .A(A),
        .B(B),
        .a_level(a_level),
        .b_level(b_level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: level flips at edge n when the synchronized value seen at each of
    // the last D edges (all after the previous flip) differs from the level.
    int n;
    int lastf [2];
    bit lvl [2];
    bit pul [2];
    bit cap [2][0:MAXE-1];

    task automatic model_reset();
        n = 0;
        for (int c = 0; c < 2; c++) begin
            lastf[c] = 0;
            lvl[c]   = 1'b0;
            pul[c]   = 1'b0;
        end
    endtask

    task automatic model_edge(input bit ra, input bit rb);
        bit ok;
        bit s;
        if (n >= MAXE - 2) begin
            $display("FAIL model_capacity edges %0d limit %0d", n, MAXE - 2);
            $fatal(1, "model history exhausted");
        end
        n++;
        cap[0][n] = ra;
        cap[1][n] = rb;
        for (int c = 0; c < 2; c++) begin
            pul[c] = 1'b0;
            if (n - lastf[c] >= D) begin
                ok = 1'b1;
                for (int e = n - D + 1; e <= n; e++) begin
                    s = (e >= 3) ? cap[c][e-2] : 1'b0;
                    if (s == lvl[c]) ok = 1'b0;
                end
                if (ok) begin
                    lvl[c]   = ~lvl[c];
                    lastf[c] = n;
                    pul[c]   = lvl[c];
                end
            end
        end
    endtask

    function automatic logic [3:0] expv();
        return {pul[0], pul[1], lvl[0], lvl[1]};
    endfunction

    task automatic tick();
        bit ra, rb;
        ra = btn_a_raw;
        rb = btn_b_raw;
        @(posedge clk);
        #1;
        if (reset) model_edge(ra, rb);
    endtask

    task automatic test_reset();
        int np;
        repeat (3) tick();
        tests++;
        if ({A, B, a_level, b_level} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hold got %b exp 0000", {A, B, a_level, b_level});
        end
        reset = 1'b1;
        btn_a_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL reset_pre cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({A, B, a_level, b_level} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_async got %b exp 0000", {A, B, a_level, b_level});
        end
        model_reset();
        btn_a_raw = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        np = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (A || B) np++;
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL idle cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        tests++;
        if (np != 0) begin
            fails++;
            $display("FAIL idle_pulses got %0d exp 0", np);
        end
    endtask

    task automatic test_clean_press();
        int k, pe, np, fe;
        btn_a_raw = 1'b1;
        k = n + 1;
        np = 0;
        pe = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (A) begin np++; pe = n; end
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL press cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        tests++;
        if (np != 1 || pe != k + D + 1) begin
            fails++;
            $display("FAIL press_timing got n=%0d edge=%0d exp n=1 edge=%0d", np, pe - k, D + 1);
        end
        btn_a_raw = 1'b0;
        k = n + 1;
        fe = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (A) np++;
            if (!a_level && fe < 0) fe = n;
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL release cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        tests++;
        if (np != 1 || fe != k + D + 1) begin
            fails++;
            $display("FAIL release_timing got n=%0d edge=%0d exp n=1 edge=%0d", np, fe - k, D + 1);
        end
    endtask

    task automatic test_bounce();
        int k, pe, np, hi;
        np = 0;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            btn_b_raw = ((i / 3) % 2 == 0);
            tick();
            if (B) np++;
            if (b_level) hi++;
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL bounce cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        tests++;
        if (np != 0 || hi != 0) begin
            fails++;
            $display("FAIL bounce_reject got pulses=%0d highs=%0d exp 0 0", np, hi);
        end
        btn_b_raw = 1'b1;
        k = n + 1;
        pe = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (B) begin np++; pe = n; end
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL bounce_hold cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        tests++;
        if (np != 1 || pe != k + D + 1) begin
            fails++;
            $display("FAIL bounce_timing got n=%0d edge=%0d exp n=1 edge=%0d", np, pe - k, D + 1);
        end
        btn_b_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_simultaneous();
        int na, nb, pa, pb;
        na = 0; nb = 0; pa = -1; pb = -1;
        btn_a_raw = 1'b1;
        btn_b_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (A) begin na++; pa = n; end
            if (B) begin nb++; pb = n; end
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL simul cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        tests++;
        if (na != 1 || nb != 1 || pa != pb) begin
            fails++;
            $display("FAIL simul_pulses got na=%0d nb=%0d ea=%0d eb=%0d exp 1 1 equal", na, nb, pa, pb);
        end
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_fast_toggle();
        int np;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            btn_a_raw = i[0];
            btn_b_raw = i[1];
            tick();
            if (A || B || a_level || b_level) np++;
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL toggle cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        tests++;
        if (np != 0) begin
            fails++;
            $display("FAIL toggle_fixed got %0d active cycles exp 0", np);
        end
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        int k, pe, np;
        np = 0;
        btn_a_raw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (A) np++;
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL mid_pre cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        reset = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (A) np++;
            tests++;
            if ({A, B, a_level, b_level} !== 4'b0000) begin
                fails++;
                $display("FAIL mid_in_reset cyc%0d got %b exp 0000", i, {A, B, a_level, b_level});
            end
        end
        reset = 1'b1;
        k = n + 1;
        pe = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (A) begin np++; pe = n; end
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL mid_post cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        tests++;
        if (np != 1 || pe != k + D + 1) begin
            fails++;
            $display("FAIL mid_timing got n=%0d edge=%0d exp n=1 edge=%0d", np, pe - k, D + 1);
        end
        btn_a_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_sequence();
        int pa, pb, na, nb, nq;
        bit armed;
        pa = -1; pb = -1; na = 0; nb = 0; nq = 0;
        armed = 1'b0;
        btn_a_raw = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) btn_b_raw = 1'b1;
            tick();
            if (B && armed) begin nq++; armed = 1'b0; end
            if (A) begin na++; pa = n; armed = 1'b1; end
            if (B) begin nb++; pb = n; end
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL seq cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        tests++;
        if (na != 1 || nb != 1 || pb - pa != 10 || nq != 1) begin
            fails++;
            $display("FAIL seq_order got na=%0d nb=%0d gap=%0d q=%0d exp 1 1 10 1", na, nb, pb - pa, nq);
        end
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int ha, hb;
        ha = 0;
        hb = 0;
        for (int i = 0; i < 600; i++) begin
            if (ha == 0) begin
                btn_a_raw = 1'($urandom_range(0, 1));
                ha = $urandom_range(1, 2 * D);
            end
            if (hb == 0) begin
                btn_b_raw = 1'($urandom_range(0, 1));
                hb = $urandom_range(1, 2 * D);
            end
            ha--;
            hb--;
            tick();
            tests++;
            if ({A, B, a_level, b_level} !== expv()) begin
                fails++;
                $display("FAIL random cyc%0d got %b exp %b", i, {A, B, a_level, b_level}, expv());
            end
        end
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_fast_toggle();
        test_reset_mid();
        test_sequence();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage that conditions two raw, asynchronous push-button/switch inputs into the clean single-cycle pulses A and B.
- These pulses feed the A-then-B sequence-detector FSM directly.
- Per channel: 2-flop synchronizer, counter-based debouncer, rising-edge pulse generator.
- Both channels are identical and fully independent.

Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive cycles the synchronized input must differ from the debounced level before the level flips. Legal range ≥ 2.
- CNT_W, default $clog2(DEBOUNCE_CYCLES): width of each debounce counter. Derived; not overridden by instantiators.

Ports:
- clk  in  1  system clock, all flops on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- btn_a_raw  in  1  raw asynchronous input, channel A
- btn_b_raw  in  1  raw asynchronous input, channel B
- A  out  1  one-cycle pulse on debounced rising edge of channel A
- B  out  1  one-cycle pulse on debounced rising edge of channel B
- a_level  out  1  debounced level, channel A
- b_level  out  1  debounced level, channel B

Behaviour:
- Reset:
  - Asynchronous on reset == 0.
  - Sync flops, counters, a_level, b_level, A and B all clear to 0 immediately.
  - Registers are held at 0 while reset is low.
- Synchronizer:
  - sync1 <= raw; sync2 <= sync1.
  - Only sync2 is used downstream.
  - No logic between the two flops.
- Debounce, per channel, evaluated each rising clk edge:
  - sync2 == level: cnt <= 0; level unchanged.
  - sync2 != level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != level and cnt == DEBOUNCE_CYCLES-1: level <= sync2; cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (at sync2) resets the counter on return and never changes level.
  - The same rules apply to rising and falling transitions.
- Pulse generation:
  - A <= 1 on exactly the edge where a_level goes 0->1; otherwise A <= 0. B is the same for channel B.
  - A and B are registered, never combinational from inputs.
  - A falling transition of level produces no pulse.
  - A pulse is exactly 1 cycle wide regardless of how long the input is held.
- Latency:
  - Raw input changes and is stable before edge k (captured in sync1 at edge k).
  - sync2 updates at edge k+1.
  - level and the pulse update at edge k+1+DEBOUNCE_CYCLES.
  - Total: 2+DEBOUNCE_CYCLES-1 = DEBOUNCE_CYCLES+1 edges after capture.
- Boundary conditions:
  - Simultaneous activity on both channels is fully independent. A and B may assert in the same cycle; the downstream FSM resolves priority.
  - Input held high through reset release: treated as a fresh rising transition. level rises and one pulse is emitted DEBOUNCE_CYCLES+1 edges after the first capture.
  - Reset asserted mid-count or mid-pulse: counters and pulses clear at once. No pulse is emitted on reset release unless the input qualifies anew.
  - Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
  - Continuous toggling faster than DEBOUNCE_CYCLES: level stays fixed indefinitely.

Test Plan:
- Reset/idle: DEBOUNCE_CYCLES=4; assert reset low mid-simulation -> A=B=a_level=b_level=0 within the same timestep. Raw inputs held 0 for 50 cycles after release -> no pulses.
- Clean press: btn_a_raw 0->1 stable, captured at edge k -> a_level=1 and A=1 for exactly one cycle after edge k+5. A=0 thereafter while held. Release after 20 cycles -> a_level=0 five edges later, no pulse.
- Bounce rejection: btn_b_raw toggles 1,0,1,0 with 3-cycle highs (< 4) -> b_level stays 0, B never asserts. Then held high -> single B pulse 5 edges after final capture.
- Simultaneous: both raw inputs rise on the same cycle -> A and B pulse in the same cycle, each exactly 1 cycle.
- Reset mid-operation: raw A high, reset asserted after 2 counted cycles, released with raw still high -> no pulse before release. Exactly one A pulse DEBOUNCE_CYCLES+1 edges after first post-reset capture.
- Sequence into downstream: A press, then B press 10 cycles later -> one A pulse followed by one B pulse, 10 cycles apart. Downstream Q observed as 1 for one cycle.
